// File: rtl/ram_dist_pkg.sv
// ram_dist_pkg: shared types, read-latency constants and depth helper for the distributed RAM.
package ram_dist_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int RD_ASYNC = 0;
    localparam int RD_SYNC  = 1;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ram_dist_clr_seq.sv
// ram_dist_clr_seq: sweeps every address once after reset or on request, driving the clear write port.
module ram_dist_clr_seq
    import ram_dist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  last;

    // depth is a power of two, so the final address is all ones
    assign last = &ptr_q;

    always_comb begin
        state_d = (state_q == CLEAR) ? (last ? IDLE : CLEAR) : (clr_i ? CLEAR : IDLE);
        ptr_d   = (state_q == CLEAR && !last) ? ptr_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o = (state_q == CLEAR);
    assign we_o   = busy_o;
    assign adr_o  = ptr_q;

endmodule

// File: rtl/ram_dist_sdp.sv
// ram_dist_sdp: simple-dual-port distributed RAM with self-clearing sweep and 0/1-cycle read latency.
module ram_dist_sdp
    import ram_dist_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 4,
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    READ_LATENCY = RD_ASYNC,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  WCLK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WADR,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [ADDR_WIDTH-1:0] RADR,
    input  logic                  CLR,
    output logic [DATA_WIDTH-1:0] O,
    output logic                  BUSY
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_dw
        $error("ram_dist_sdp: DATA_WIDTH must be 1..64");
    end
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_bad_aw
        $error("ram_dist_sdp: ADDR_WIDTH must be 4..10");
    end
    if (READ_LATENCY != RD_ASYNC && READ_LATENCY != RD_SYNC) begin : g_bad_rl
        $error("ram_dist_sdp: READ_LATENCY must be 0 or 1");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_adr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_adr;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

    ram_dist_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
        .clk_i  (WCLK),
        .rst_i  (RST),
        .clr_i  (CLR),
        .busy_o (BUSY),
        .we_o   (clr_we),
        .adr_o  (clr_adr)
    );

    // the sweep owns the write port while busy, so user writes are dropped then
    assign wr_en  = !RST && (clr_we || WE);
    assign wr_adr = clr_we ? clr_adr : WADR;
    assign wr_dat = clr_we ? INIT_VALUE : D;

    always_ff @(posedge WCLK) begin
        if (wr_en) mem_q[wr_adr] <= wr_dat;
    end

    if (READ_LATENCY == RD_SYNC) begin : g_sync
        logic [DATA_WIDTH-1:0] o_q = INIT_VALUE;
        always_ff @(posedge WCLK) begin
            o_q <= RST ? INIT_VALUE : mem_q[RADR];
        end
        assign O = o_q;
    end else begin : g_async
        assign O = mem_q[RADR];
    end

endmodule

// File: doc/ram_dist_sdp.md
# ram_dist_sdp

Parametrised simple-dual-port distributed RAM: one synchronous write port, one independent read port, and a selectable read latency of 0 or 1. A hardware clear sequencer loads every word with `INIT_VALUE` after reset or on request. It generalises the fixed 32x4 single-address static RAM to arbitrary width/depth, separate read/write addresses, and self-initialisation. It sits beside LUT-RAM primitives for register files, small FIFOs and lookup tables.

## Interface
- `DATA_WIDTH`, default 4: word width, 1..64.
- `ADDR_WIDTH`, default 5: depth = 2**ADDR_WIDTH, 4..10.
- `READ_LATENCY`, default 0: 0 = asynchronous read, 1 = registered read.
- `INIT_VALUE`, default 0: `DATA_WIDTH`-bit word written by the clear sequence and used as the power-up content.

- `WCLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `WE`  in  1  write enable; ignored while `BUSY`.
- `WADR`  in  ADDR_WIDTH  write address.
- `D`  in  DATA_WIDTH  write data.
- `RADR`  in  ADDR_WIDTH  read address.
- `CLR`  in  1  single-cycle request to re-initialise the whole array.
- `O`  out  DATA_WIDTH  read data.
- `BUSY`  out  1  clear sequence in progress.

## Operation
- FSM states: IDLE and CLEAR. A `ptr` counter is ADDR_WIDTH bits wide.
- With `RST`=1 at an edge:
  - FSM goes to CLEAR, `ptr`←0, `BUSY`←1.
  - If READ_LATENCY=1, `O`←INIT_VALUE.
  - The memory array is not written during that edge.
- In CLEAR, each edge:
  - writes INIT_VALUE to `mem[ptr]`.
  - if `ptr`==DEPTH-1, goes to IDLE with `BUSY`←0 and `ptr`←0; otherwise `ptr`←`ptr`+1.
- In IDLE:
  - `WE`=1 writes `D` to `mem[WADR]` at the edge.
  - `CLR`=1 moves to CLEAR with `ptr`←0 and `BUSY`←1. The user write is still performed that same edge.
- `CLR` while in CLEAR is ignored; the sweep does not restart.
- `WE` while `BUSY` is dropped silently; nothing is queued.
- `RST` mid-clear restarts the sweep from address 0.
- Read path:
  - READ_LATENCY=0: `O` = `mem[RADR]` combinationally.
  - READ_LATENCY=1: `O`←`mem[RADR]` at each edge when `RST`=0, including while `BUSY`.
- Read/write collision (`RADR`==`WADR` with a write at the same edge; applies to user and clear writes alike):
  - Latency 0: `O` shows old data before the edge and new data after it.
  - Latency 1: read-first; `O` captures the old data.
- Power-up: the array holds INIT_VALUE, so `O` is never X before the first clear completes.

## Timing
- After `RST` deasserts, `BUSY` stays high for exactly DEPTH cycles (32 at defaults). The first accepted write is in cycle DEPTH+1.
- `CLR` sampled at edge k in IDLE: `BUSY`=1 from k through k+DEPTH-1, and low after edge k+DEPTH.
- Write-to-read visibility: latency 0 in the same cycle after the edge; latency 1 one edge later.
- `BUSY` is a registered output; no combinational path from any input to `BUSY`.
- Latency 0 has a combinational path `RADR`→`O`. Latency 1 has none.

## Structure
- Package `ram_dist_pkg` holds:
  - the FSM state typedef (IDLE, CLEAR).
  - `RD_ASYNC`=0 and `RD_SYNC`=1 latency constants.
  - a `depth(aw)` function.
- Sub-module `ram_dist_clr_seq`: FSM plus `ptr` counter, producing `BUSY`, the clear write enable and the clear address.
- The top level muxes the write port between user and clear sources and contains the array and the read path.
- Elaboration-time error on out-of-range `ADDR_WIDTH`, `DATA_WIDTH` or `READ_LATENCY`.

## Test plan
- Reset release with defaults: `BUSY` high for 32 cycles, then low. Reading all 32 addresses returns 0x0. `WE`=1 with `D`=0xF during `BUSY` leaves every word 0x0.
- Latency 0, IDLE: write `WADR`=5, `D`=0xA with `RADR`=5. `O` reads the old value 0x0 before the edge and 0xA after it.
- READ_LATENCY=1, DATA_WIDTH=8: write 0x5A to address 3 while `RADR`=3. `O`=old value (INIT_VALUE) after that edge, and 0x5A after the next edge.
- Address extremes: write 0x1 to address 0 and 0x2 to address 31. Read 31 then 0 and get 0x2, 0x1; address 16 still reads 0x0.
- Fill with pattern `i`, pulse `CLR` for one cycle:
  - `BUSY` is high for 32 cycles.
  - a second `CLR` at cycle 10 does not extend `BUSY`.
  - afterwards all words equal INIT_VALUE.
- Assert `RST` at clear cycle 20, then release: `BUSY` lasts a full 32 cycles from release. With READ_LATENCY=1, `O`=INIT_VALUE right after the reset edge.
